spi_slave_regfile: RTL and testbench

Parametrised configuration register file for the SPI slave, the successor to the fixed four-register block. It sits between the SPI command decoder and the datapath, and holds NUM_REGS registers of REG_SIZE bits. It adds burst access with address auto-increment and a shadow/active split, so multi-byte fields such as `wrap_length` update atomically. It also adds a write-lock bit, a sticky write-error flag, and a read-only status register.

---
 rtl/spi_slave_regfile_if.sv | 29 ++
 rtl/spi_slave_regfile.sv | 103 ++++++++++
 tb/tb_spi_slave_regfile.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/spi_slave_regfile_if.sv
// Command/read bus between the SPI command decoder and the register file.
// The decoder drives commands; the register file returns read data.
interface spi_slave_regfile_if #(
  parameter int REG_SIZE = 8,
  parameter int AW = 3
);
  logic                wr_start;
  logic [AW-1:0]       wr_addr;
  logic [REG_SIZE-1:0] wr_data;
  logic                wr_data_valid;
  logic                wr_end;
  logic                rd_start;
  logic [AW-1:0]       rd_addr;
  logic                rd_next;
  logic [REG_SIZE-1:0] rd_data;
  logic                err_clr;

  modport master (
    output wr_start, wr_addr, wr_data, wr_data_valid, wr_end,
    output rd_start, rd_addr, rd_next, err_clr,
    input  rd_data
  );

  modport slave (
    input  wr_start, wr_addr, wr_data, wr_data_valid, wr_end,
    input  rd_start, rd_addr, rd_next, err_clr,
    output rd_data
  );
endinterface

// File: rtl/spi_slave_regfile.sv
// SPI slave configuration register file: burst access, shadow/active
// split for regs 0..3, write lock, sticky write error, status register.
module spi_slave_regfile #(
  parameter int REG_SIZE = 8,
  parameter int NUM_REGS = 8,
  parameter int QUAD_EN = 0,
  parameter int DUMMY_RST = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic                  sclk,
  input  logic                  rst,
  spi_slave_regfile_if.slave    bus,
  output logic                  en_qpi,
  output logic [7:0]            dummy_cycles,
  output logic [15:0]           wrap_length,
  output logic                  wr_err
);

  localparam logic [AW-1:0] STAT = AW'(NUM_REGS - 1);
  localparam logic [REG_SIZE-1:0] R0_RST = REG_SIZE'(QUAD_EN % 2);
  localparam logic [REG_SIZE-1:0] R1_RST = REG_SIZE'(DUMMY_RST);

  logic [REG_SIZE-1:0] shadow     [NUM_REGS-1];
  logic [REG_SIZE-1:0] shadow_nxt [NUM_REGS-1];
  logic [REG_SIZE-1:0] stat;
  logic [AW-1:0]       wptr;
  logic [AW-1:0]       rptr;
  logic [AW-1:0]       tgt;
  logic [3:0]          cnt;
  logic                pending;
  logic                lock_hit;
  logic                bad;
  logic                wr_ok;

  // Lock is judged on the registered shadow reg0, so it bites one cycle late
  always_comb begin
    tgt = bus.wr_start ? bus.wr_addr : wptr;
    lock_hit = shadow[0][7] && (tgt != '0) && (tgt < AW'(4));
    bad = bus.wr_data_valid && ((tgt == STAT) || lock_hit);
    wr_ok = bus.wr_data_valid && !bad;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      shadow_nxt[i] = shadow[i];
    end
    if (wr_ok) begin
      shadow_nxt[tgt] = bus.wr_data;
    end
  end

  always_comb begin
    stat = '0;
    stat[0] = wr_err;
    stat[1] = pending;
    stat[7:4] = cnt;
  end

  assign bus.rd_data = (rptr == STAT) ? stat : shadow[rptr];

  always_ff @(posedge sclk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        shadow[i] <= '0;
      end
      shadow[0] <= R0_RST;
      shadow[1] <= R1_RST;
      en_qpi <= R0_RST[0];
      dummy_cycles <= R1_RST[7:0];
      wrap_length <= '0;
      wptr <= '0;
      rptr <= '0;
      pending <= 1'b0;
      cnt <= '0;
      wr_err <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        shadow[i] <= shadow_nxt[i];
      end
      if (bus.wr_start || bus.wr_data_valid) begin
        wptr <= tgt + AW'(bus.wr_data_valid);
      end
      if (bus.rd_start) begin
        rptr <= bus.rd_addr;
      end else if (bus.rd_next) begin
        rptr <= rptr + AW'(1);
      end
      // Commit sees this cycle's write via shadow_nxt
      if (bus.wr_end) begin
        en_qpi <= shadow_nxt[0][0];
        dummy_cycles <= shadow_nxt[1][7:0];
        wrap_length <= {shadow_nxt[3][7:0], shadow_nxt[2][7:0]};
        pending <= 1'b0;
        cnt <= cnt + 4'd1;
      end else if (wr_ok && (tgt < AW'(4))) begin
        pending <= 1'b1;
      end
      if (bad) begin
        wr_err <= 1'b1;
      end else if (bus.err_clr) begin
        wr_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed bench for spi_slave_regfile (8 x 8-bit, QUAD_EN=1).
// Inputs change 1 time unit after a rising edge and are sampled there.
module tb_spi_slave_regfile;
  logic        sclk;
  logic        rst;
  logic        en_qpi;
  logic [7:0]  dummy_cycles;
  logic [15:0] wrap_length;
  logic        wr_err;
  int          checks;
  int          failures;

  spi_slave_regfile_if #(.REG_SIZE(8), .AW(3)) bus ();

  spi_slave_regfile #(
    .REG_SIZE(8),
    .NUM_REGS(8),
    .QUAD_EN(1),
    .DUMMY_RST(32)
  ) dut (
    .sclk(sclk),
    .rst(rst),
    .bus(bus),
    .en_qpi(en_qpi),
    .dummy_cycles(dummy_cycles),
    .wrap_length(wrap_length),
    .wr_err(wr_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sclk);
    #1;
    bus.wr_start = 1'b0;
    bus.wr_data_valid = 1'b0;
    bus.wr_end = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_next = 1'b0;
    bus.err_clr = 1'b0;
  endtask

  task automatic rd_at(input logic [2:0] a);
    bus.rd_start = 1'b1;
    bus.rd_addr = a;
    cyc();
  endtask

  task automatic wr_at(input logic [2:0] a, input logic [7:0] d,
                       input logic commit);
    bus.wr_start = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_data_valid = 1'b1;
    bus.wr_end = commit;
    cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.wr_start = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.wr_data_valid = 1'b0;
    bus.wr_end = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_addr = '0;
    bus.rd_next = 1'b0;
    bus.err_clr = 1'b0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;

    // reset defaults
    chk("rst_en_qpi", 16'(en_qpi), 16'h1);
    chk("rst_dummy", 16'(dummy_cycles), 16'd32);
    chk("rst_wrap", wrap_length, 16'h0);
    chk("rst_err", 16'(wr_err), 16'h0);
    chk("rst_rd0", 16'(bus.rd_data), 16'h01);
    rd_at(3'd7);
    chk("rst_status", 16'(bus.rd_data), 16'h00);

    // atomic burst into wrap length
    wr_at(3'd2, 8'h34, 1'b0);
    bus.wr_data = 8'h12;
    bus.wr_data_valid = 1'b1;
    cyc();
    chk("burst_wrap_held", wrap_length, 16'h0);
    chk("burst_pending", 16'(bus.rd_data), 16'h02);
    bus.wr_end = 1'b1;
    cyc();
    chk("burst_wrap", wrap_length, 16'h1234);
    chk("burst_status", 16'(bus.rd_data), 16'h10);
    rd_at(3'd2);
    chk("burst_rd2", 16'(bus.rd_data), 16'h34);
    bus.rd_next = 1'b1;
    cyc();
    chk("burst_rd3", 16'(bus.rd_data), 16'h12);

    // wrap-around through status register
    wr_at(3'd6, 8'hAA, 1'b0);
    bus.wr_data = 8'hBB;
    bus.wr_data_valid = 1'b1;
    cyc();
    chk("wrap_err", 16'(wr_err), 16'h1);
    bus.wr_data = 8'hCC;
    bus.wr_data_valid = 1'b1;
    cyc();
    rd_at(3'd6);
    chk("wrap_rd6", 16'(bus.rd_data), 16'hAA);
    rd_at(3'd0);
    chk("wrap_rd0", 16'(bus.rd_data), 16'hCC);
    chk("wrap_no_commit", 16'(en_qpi), 16'h1);

    // lock
    wr_at(3'd0, 8'h80, 1'b1);
    chk("lock_en_qpi", 16'(en_qpi), 16'h0);
    bus.err_clr = 1'b1;
    cyc();
    chk("errclr_alone", 16'(wr_err), 16'h0);
    wr_at(3'd1, 8'h08, 1'b1);
    chk("lock_err", 16'(wr_err), 16'h1);
    chk("lock_dummy", 16'(dummy_cycles), 16'd32);
    rd_at(3'd1);
    chk("lock_rd1", 16'(bus.rd_data), 16'h20);
    wr_at(3'd0, 8'h00, 1'b0);
    wr_at(3'd1, 8'h08, 1'b1);
    chk("unlock_dummy", 16'(dummy_cycles), 16'd8);
    chk("unlock_rd1", 16'(bus.rd_data), 16'h08);
    rd_at(3'd7);
    chk("count_status", 16'(bus.rd_data), 16'h41);

    // err_clr against a same-cycle error
    bus.err_clr = 1'b1;
    wr_at(3'd7, 8'h55, 1'b0);
    chk("errclr_vs_err", 16'(wr_err), 16'h1);
    bus.err_clr = 1'b1;
    cyc();
    chk("errclr_clears", 16'(wr_err), 16'h0);
    chk("errclr_status", 16'(bus.rd_data), 16'h40);

    // reset mid-burst
    wr_at(3'd4, 8'h77, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_en_qpi", 16'(en_qpi), 16'h1);
    chk("mid_dummy", 16'(dummy_cycles), 16'd32);
    chk("mid_wrap", wrap_length, 16'h0);
    chk("mid_err", 16'(wr_err), 16'h0);
    chk("mid_rd0", 16'(bus.rd_data), 16'h01);
    rd_at(3'd4);
    chk("mid_rd4", 16'(bus.rd_data), 16'h00);
    rd_at(3'd0);
    bus.wr_data = 8'h5A;
    bus.wr_data_valid = 1'b1;
    #1;
    chk("same_cycle_old", 16'(bus.rd_data), 16'h01);
    cyc();
    chk("mid_wptr0", 16'(bus.rd_data), 16'h5A);
    chk("mid_no_commit", 16'(en_qpi), 16'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
